regfile_access_ctrl: RTL

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: one command per IDLE->ACCESS->RESP pass, with a sticky write lock over PROT_BASE..31.
// Optional macro REGFILE_ACC_DEBUG_OVERRIDE_EN lets debug_unlocked bypass the lock during ACCESS.
module regfile_access_ctrl #(
    parameter logic [4:0] PROT_BASE = 5'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        lock_set,
    input  logic        debug_unlocked,
    output logic        lock_status,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_we
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_lock;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_override;
    logic        w_blocked;
    logic        w_write_ok;

`ifdef REGFILE_ACC_DEBUG_OVERRIDE_EN
    assign w_override = debug_unlocked;
`else
    assign w_override = debug_unlocked & 1'b0;
`endif

    // Lock is judged on the registered state during ACCESS, so a lock_set
    // arriving in that same cycle only takes effect for later commands.
    assign w_blocked  = r_write && (r_addr != '0) && (r_addr >= PROT_BASE)
                        && r_lock && !w_override;
    assign w_write_ok = r_write && (r_addr != '0) && !w_blocked;

    assign req_ready   = (r_state == S_IDLE);
    assign rf_we       = (r_state == S_ACCESS) && w_write_ok;
    assign rf_raddr    = r_addr;
    assign rf_waddr    = r_addr;
    assign rf_wdata    = r_wdata;
    assign lock_status = r_lock;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lock      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (lock_set) begin
                r_lock <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_blocked;
                    r_rsp_rdata <= r_write ? '0 : rf_rdata;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
